// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive engine: FSM encodings, frame-length
// constants, FIFO word layout and the 2-of-3 majority helper.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_e;

  localparam int DATA7 = 7;
  localparam int DATA8 = 8;

  // FIFO word layout: {FERR, PERR, data[7:0]}
  localparam int WORD_W   = 10;
  localparam int DATA_LSB = 0;
  localparam int PERR_POS = 8;
  localparam int FERR_POS = 9;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head word reads 0 when empty.
// drop_o flags a push refused because the FIFO was full with no pop.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & full & ~do_pop;
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive engine with oversampled bit timing, break handling and a receive FIFO.
// Define UART_RX_MAJORITY_EN to take every line sample as a 2-of-3 majority vote.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int K_WIDTH     = 19,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        RX,
  input  logic                        EIGHT,
  input  logic                        PEN,
  input  logic                        OHEL,
  input  logic [K_WIDTH-1:0]          K,
  input  logic                        READS0,
  input  logic                        CLR_OVF,
  output logic [7:0]                  UART_RDATA,
  output logic                        RXRDY,
  output logic                        PERR,
  output logic                        FERR,
  output logic                        OVF,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);

  rx_state_e          state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               rxs;
  logic               sample;
  logic [K_WIDTH-1:0] cnt_q, cnt_d;
  logic [K_WIDTH-1:0] tval;
  logic               btu;
  logic [2:0]         bit_q, bit_d;
  logic [2:0]         last_bit;
  logic [7:0]         data_q, data_d;
  logic               par_q, par_d;
  logic               eight_q, eight_d;
  logic               pen_q, pen_d;
  logic               ohel_q, ohel_d;
  logic               ovf_q, ovf_d;
  logic               push;
  logic [WORD_W-1:0]  push_word;
  logic [WORD_W-1:0]  head_word;
  logic               fifo_empty;
  logic               fifo_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist_q <= '1;
    else          hist_q <= {hist_q[0], rxs};
  end
  assign sample = maj3({hist_q, rxs});
`else
  assign sample = rxs;
`endif

  // START waits half a bit so every later sample lands mid-bit
  assign tval     = (state_q == START) ? (K >> 1) : K;
  assign btu      = (cnt_q == tval - K_WIDTH'(1));
  assign last_bit = eight_q ? 3'(DATA8 - 1) : 3'(DATA7 - 1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = btu ? '0 : cnt_q + K_WIDTH'(1);
    bit_d     = bit_q;
    data_d    = data_q;
    par_d     = par_q;
    eight_d   = eight_q;
    pen_d     = pen_q;
    ohel_d    = ohel_q;
    push      = 1'b0;
    push_word = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = START;
          eight_d = EIGHT;
          pen_d   = PEN;
          ohel_d  = OHEL;
          data_d  = '0;
          bit_d   = '0;
          par_d   = 1'b0;
        end
      end
      START: begin
        if (btu) state_d = sample ? IDLE : DATA;
      end
      DATA: begin
        if (btu) begin
          data_d[bit_q] = sample;
          if (bit_q == last_bit) begin
            bit_d   = '0;
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (btu) begin
          par_d   = sample;
          state_d = STOP;
        end
      end
      STOP: begin
        if (btu) begin
          push                = 1'b1;
          push_word[FERR_POS] = ~sample;
          push_word[PERR_POS] = pen_q & (par_q != (^data_q ^ ohel_q));
          push_word[DATA_LSB +: 8] = data_q;
          state_d = sample ? IDLE : BRK_WAIT;
        end
      end
      BRK_WAIT: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A fresh overflow outranks a simultaneous clear
  assign ovf_d = fifo_drop ? 1'b1 : (CLR_OVF ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      eight_q <= eight_d;
      pen_q   <= pen_d;
      ohel_q  <= ohel_d;
      ovf_q   <= ovf_d;
    end
  end

  rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (READS0),
    .rdata_o (head_word),
    .empty_o (fifo_empty),
    .count_o (FIFO_COUNT),
    .drop_o  (fifo_drop)
  );

  assign UART_RDATA = head_word[DATA_LSB +: 8];
  assign PERR       = head_word[PERR_POS];
  assign FERR       = head_word[FERR_POS];
  assign RXRDY      = ~fifo_empty;
  assign OVF        = ovf_q;

endmodule
